fw_ctrl: RTL and testbench



---
 rtl/fw_ctrl.sv | 84 ++++++++
 tb/tb_fw_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fw_ctrl.sv
// Farm-way light controller: rests in RED, runs YELLOW then GREEN on invk_fw,
// and hands right-of-way back to the highway by pulsing invk_hw.
module fw_ctrl #(
    parameter int unsigned SHORT_CYCLES = 3,
    parameter int unsigned LONG_CYCLES  = 8,
    parameter int unsigned MIN_GREEN    = 2,
    localparam int unsigned TW          = $clog2(LONG_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          invk_fw,
    input  logic          car_on_fw,
    output logic          invk_hw,
    output logic          fw_red,
    output logic          fw_yellow,
    output logic          fw_green,
    output logic [TW-1:0] timer_val,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } state_e;

    localparam logic [TW-1:0] SHORT_LAST = TW'(SHORT_CYCLES - 1);
    localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] MIN_LAST   = TW'(MIN_GREEN - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          perr_q;
    logic          red_q, yellow_q, green_q;
    logic          exit_x;

    always_comb begin
        exit_x  = (timer_q == LONG_LAST) || (!car_on_fw && (timer_q >= MIN_LAST));
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            RED: begin
                if (invk_fw) state_d = YELLOW;
            end
            YELLOW: begin
                if (timer_q == SHORT_LAST) state_d = GREEN;
                else                       timer_d = timer_q + TW'(1);
            end
            GREEN: begin
                if (exit_x) state_d = RED;
                else        timer_d = timer_q + TW'(1);
            end
            default: state_d = RED;
        endcase
    end

    // Lamps are registered from the next state, so they always match state_q
    // without any input-to-lamp combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RED;
            timer_q  <= '0;
            perr_q   <= 1'b0;
            red_q    <= 1'b1;
            yellow_q <= 1'b0;
            green_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            if (invk_fw && (state_q != RED)) perr_q <= 1'b1;
            red_q    <= (state_d == RED);
            yellow_q <= (state_d == YELLOW);
            green_q  <= (state_d == GREEN);
        end
    end

    assign invk_hw   = !reset && (state_q == GREEN) && exit_x;
    assign fw_red    = red_q;
    assign fw_yellow = yellow_q;
    assign fw_green  = green_q;
    assign timer_val = timer_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_fw_ctrl.sv
// Self-checking bench for fw_ctrl: directed scenarios followed by random traffic,
// checked against a phase/start-cycle reference model.
module tb_fw_ctrl;

    localparam int unsigned S  = 3;
    localparam int unsigned L  = 8;
    localparam int unsigned M  = 2;
    localparam int unsigned TW = $clog2(L);

    logic          clk = 1'b0;
    logic          reset, invk_fw, car_on_fw;
    logic          invk_hw, fw_red, fw_yellow, fw_green, proto_err;
    logic [TW-1:0] timer_val;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=red 1=yellow 2=green, with the absolute cycle
    // at which the phase began; the timer is simply elapsed cycles in phase.
    int m_phase = 0;
    int m_start = 0;
    int now     = 0;
    bit m_perr  = 0;
    int green_obs = 0;
    int hw_cnt    = 0;

    fw_ctrl #(.SHORT_CYCLES(S), .LONG_CYCLES(L), .MIN_GREEN(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .invk_fw   (invk_fw),
        .car_on_fw (car_on_fw),
        .invk_hw   (invk_hw),
        .fw_red    (fw_red),
        .fw_yellow (fw_yellow),
        .fw_green  (fw_green),
        .timer_val (timer_val),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic cyc(input bit r, input bit inv, input bit car, input bit chk);
        int el;
        bit x;
        bit exp_hw;
        reset = r; invk_fw = inv; car_on_fw = car;
        #1;
        el     = now - m_start;
        x      = (el == L - 1) || (!car && el >= M - 1);
        exp_hw = !r && (m_phase == 2) && x;
        if (chk) begin
            check("lamps", {29'd0, fw_red, fw_yellow, fw_green},
                  {29'd0, m_phase == 0, m_phase == 1, m_phase == 2});
            check("timer", timer_val, (m_phase == 0) ? 0 : el);
            check("invk_hw", invk_hw, exp_hw);
            check("proto_err", proto_err, m_perr);
            if (fw_green === 1'b1) green_obs++;
            else                   green_obs = 0;
            if (exp_hw) check("grn_range", (green_obs >= M) && (green_obs <= L), 1);
        end
        if (invk_hw === 1'b1) hw_cnt++;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_start = now + 1; m_perr = 0;
        end else begin
            if (inv && m_phase != 0) m_perr = 1;
            case (m_phase)
                0: if (inv) begin m_phase = 1; m_start = now + 1; end
                1: if (el == S - 1) begin m_phase = 2; m_start = now + 1; end
                default: if (x) begin m_phase = 0; m_start = now + 1; end
            endcase
        end
        now++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; invk_fw = 1'b0; car_on_fw = 1'b0;
        @(negedge clk);
        // Reset and idle
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);

        // Max-green path
        hw_cnt = 0;
        cyc(0, 1, 1, 1);
        repeat (12) cyc(0, 0, 1, 1);
        check("s2_hw_pulses", hw_cnt, 1);
        cyc(0, 0, 1, 1);

        // Immediate release
        hw_cnt = 0;
        cyc(0, 1, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);
        check("s3_hw_pulses", hw_cnt, 1);

        // Mid-green release at green timer 4
        cyc(0, 1, 1, 1);
        repeat (7) cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 1);

        // Protocol error during yellow, sticky through red
        cyc(0, 1, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        repeat (12) cyc(0, 0, 1, 1);
        check("s5_perr_sticky", proto_err, 1);

        // Reset at green timer 3 with no car, then replay immediate release
        cyc(0, 1, 1, 1);
        repeat (6) cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 1);
        hw_cnt = 0;
        cyc(0, 1, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);
        check("s6_hw_pulses", hw_cnt, 1);

        // Random traffic
        repeat (3000) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
